// File: rtl/mem_dump_uart.sv
// mem_dump_uart: reads a range of core data-memory words and streams them out as 8N1 UART bytes, LSB byte first
// Ports: sys_clk/sys_rst_n clock and async active-low reset; start/start_addr/word_count dump request;
//   data_flag/data_addr/data_in core read port; uart_tx serial line; busy during dump; done completion pulse
module mem_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] word_count,
  output logic        data_flag,
  output logic [15:0] data_addr,
  input  logic [31:0] data_in,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] LAT_MAX = 2'(RD_LATENCY);
  localparam logic [15:0] STEP = 16'(ADDR_STEP);
  typedef enum logic [1:0] {IDLE, REQ, SEND, FIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] clk_cnt;
  logic [5:0] bit_cnt;
  logic [1:0] lat_cnt;
  logic [15:0] words;
  logic [39:0] frame;
  logic bit_end, lat_end, word_end;
  assign bit_end = clk_cnt == CLK_MAX;
  assign lat_end = lat_cnt == LAT_MAX;
  assign word_end = state == SEND && bit_end && bit_cnt == 6'd39;
  // the whole word is preloaded as four start/data/stop frames and shifted out with
  // ones filling in, so the line idles high with no output mux
  assign uart_tx = frame[0];
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    data_flag = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) state_nx = word_count == 16'd0 ? FIN : REQ;
      REQ: begin
        data_flag = 1'b1;
        busy = 1'b1;
        if (lat_end) state_nx = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (word_end) state_nx = words == 16'd1 ? FIN : REQ;
      end
      FIN: begin
        done = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      data_addr <= 16'd0;
      words <= 16'd0;
      lat_cnt <= 2'd0;
      clk_cnt <= '0;
      bit_cnt <= 6'd0;
      frame <= '1;
    end else begin
      if (state == IDLE && start && word_count != 16'd0) begin
        data_addr <= start_addr;
        words <= word_count;
      end
      lat_cnt <= state == REQ && !lat_end ? lat_cnt + 2'd1 : 2'd0;
      clk_cnt <= state == SEND && !bit_end ? clk_cnt + 1'b1 : '0;
      if (state == REQ && lat_end)
        frame <= {1'b1, data_in[31:24], 1'b0, 1'b1, data_in[23:16], 1'b0,
                  1'b1, data_in[15:8], 1'b0, 1'b1, data_in[7:0], 1'b0};
      else if (state == SEND && bit_end)
        frame <= {1'b1, frame[39:1]};
      if (state == SEND && bit_end) bit_cnt <= bit_cnt == 6'd39 ? 6'd0 : bit_cnt + 6'd1;
      if (word_end) begin
        words <= words - 16'd1;
        if (words != 16'd1) data_addr <= data_addr + STEP;
      end
    end
endmodule

// File: tb/tb_mem_dump_uart.sv
// tb_mem_dump_uart: scoreboard bench for mem_dump_uart with a latency-1 memory model and a UART decoder
module tb_mem_dump_uart;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic sys_rst_n = 1'b1;
  logic start = 1'b0;
  logic [15:0] start_addr = 16'd0;
  logic [15:0] word_count = 16'd0;
  logic data_flag, uart_tx, busy, done;
  logic [15:0] data_addr;
  logic [31:0] data_in;
  logic flag_d = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_bytes[$];
  logic [15:0] exp_addr[$];
  int exp_done = 0;

  mem_dump_uart #(.CLKS_PER_BIT(CPB), .RD_LATENCY(1), .ADDR_STEP(4)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .data_flag(data_flag), .data_addr(data_addr),
    .data_in(data_in), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: return 32'hA1B2C3D4;
      16'hFFFC: return 32'h11223344;
      16'h0000: return 32'h55667788;
      16'h0004: return 32'h99AABBCC;
      16'h0100: return 32'h01020304;
      16'h0104: return 32'h05060708;
      16'h0200: return 32'hFFEEDDCC;
      16'h0030: return 32'h77660055;
      16'h0020: return 32'h0BADF00D;
      default:  return {a, ~a};
    endcase
  endfunction

  // memory answers only from the second cycle of a held request; earlier or later reads see garbage
  always @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) flag_d <= 1'b0;
    else flag_d <= data_flag;
  assign data_in = (data_flag && flag_d) ? mem_word(data_addr) : 32'hDEADBEEF;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] a);
    logic [31:0] w;
    w = mem_word(a);
    exp_addr.push_back(a);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(w[8*i +: 8]);
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] n);
    @(negedge clk);
    start_addr = a;
    word_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(nm, done, 1'b1);
  endtask

  task automatic wait_flag_fall();
    int n;
    n = 0;
    while (data_flag && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("flag_fall_seen", data_flag, 1'b0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_tx"}, uart_tx, 1'b1);
    check({nm, "_busy"}, busy, 1'b0);
    check({nm, "_done"}, done, 1'b0);
    check({nm, "_flag"}, data_flag, 1'b0);
    check({nm, "_addr"}, data_addr, 16'h0000);
  endtask

  int r_len = 0;
  logic r_prev = 1'b0;
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      r_prev = 1'b0;
      r_len = 0;
    end else begin
      if (data_flag && !r_prev) begin
        r_len = 0;
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL read_extra actual=%0h expected=none", data_addr);
        end else check("read_addr", data_addr, exp_addr.pop_front());
      end
      if (data_flag) r_len++;
      if (!data_flag && r_prev) check("flag_len", r_len, 2);
      r_prev = data_flag;
    end
  end

  always @(negedge clk) begin
    if (sys_rst_n && done) begin
      check("done_busy_low", busy, 1'b0);
      if (exp_done == 0) begin
        checks++;
        failures++;
        $display("FAIL done_extra actual=1 expected=0");
      end else exp_done--;
    end
  end

  logic u_act = 1'b0;
  int u_cnt = 0;
  int u_idx = 0;
  int u_last = 0;
  logic [7:0] u_sh = 8'h00;
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      u_act = 1'b0;
      u_idx = 0;
    end else if (!u_act) begin
      if (!uart_tx) begin
        u_act = 1'b1;
        u_cnt = 0;
        if (u_idx % 4 != 0) check("byte_gap", cyc - u_last, 10 * CPB);
        u_last = cyc;
      end
    end else begin
      u_cnt++;
      if (u_cnt % CPB == CPB / 2) begin
        if (u_cnt / CPB == 0) check("start_bit", uart_tx, 1'b0);
        else if (u_cnt / CPB <= 8) u_sh[u_cnt / CPB - 1] = uart_tx;
        else begin
          check("stop_bit", uart_tx, 1'b1);
          if (exp_bytes.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL byte_extra actual=%0h expected=none", u_sh);
          end else check("uart_byte", u_sh, exp_bytes.pop_front());
          u_act = 1'b0;
          u_idx++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int bad;
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("reset_init");
    #20 sys_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // single word with frame-length timing
    push_word(16'h0010);
    exp_done++;
    pulse_start(16'h0010, 16'd1);
    check("busy_after_start", busy, 1'b1);
    check("flag_after_start", data_flag, 1'b1);
    wait_flag_fall();
    t0 = cyc;
    wait_done("single_done");
    check("single_frame_cycles", cyc - t0, 40 * CPB);
    @(negedge clk);
    check("single_busy_after", busy, 1'b0);
    check("single_addr_hold", data_addr, 16'h0010);
    // address wrap across 0xFFFC
    repeat (3) @(negedge clk);
    push_word(16'hFFFC);
    push_word(16'h0000);
    push_word(16'h0004);
    exp_done++;
    pulse_start(16'hFFFC, 16'd3);
    wait_done("wrap_done");
    @(negedge clk);
    check("wrap_addr_hold", data_addr, 16'h0004);
    // zero count
    exp_done++;
    pulse_start(16'h0040, 16'd0);
    check("zero_done_pulse", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || data_flag || !uart_tx || done) bad++;
    end
    check("zero_quiet", bad, 0);
    // start while busy is ignored
    push_word(16'h0100);
    push_word(16'h0104);
    exp_done++;
    pulse_start(16'h0100, 16'd2);
    repeat (50) @(negedge clk);
    pulse_start(16'h0200, 16'd1);
    wait_done("ignored_done");
    repeat (5) @(negedge clk);
    check("ignored_bytes_left", exp_bytes.size(), 0);
    // reset during byte1 data bit 3 (a zero bit)
    push_word(16'h0030);
    exp_done++;
    pulse_start(16'h0030, 16'd1);
    wait_flag_fall();
    repeat (57) @(negedge clk);
    check("pre_reset_tx_low", uart_tx, 1'b0);
    #1 sys_rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    exp_bytes.delete();
    exp_addr.delete();
    exp_done = 0;
    #30 sys_rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_tx", uart_tx, 1'b1);
    push_word(16'h0020);
    exp_done++;
    pulse_start(16'h0020, 16'd1);
    wait_done("post_reset_done");
    repeat (5) @(negedge clk);
    check("end_bytes_left", exp_bytes.size(), 0);
    check("end_reads_left", exp_addr.size(), 0);
    check("end_done_left", exp_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
